sw_debounce: RTL and testbench

SW_DEBOUNCE -- requirements
Module: sw_debounce

---
 rtl/sw_debounce.sv | 92 +++++++++
 tb/tb_sw_debounce.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce: per-channel switch debouncer.
// Each raw switch bit is synchronised through two flops, then must disagree
// with its accepted level for STABLE_CYCLES consecutive clock edges before the
// new level is accepted. Accepted edges produce one-cycle rise/fall pulses.
// All outputs come straight from flops, so nothing combinational reaches the
// downstream mux tree from the bouncing inputs.
module sw_debounce #(
    parameter int WIDTH         = 18,
    parameter int STABLE_CYCLES = 500000
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             busy
);

    // Counter just wide enough to hold STABLE_CYCLES-1; it is cleared on
    // acceptance so it never has to represent STABLE_CYCLES itself.
    localparam int CNT_W = ($clog2(STABLE_CYCLES) < 1) ? 1 : $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] clean_next;
    logic [WIDTH-1:0] rise_next;
    logic [WIDTH-1:0] fall_next;

    // Two-flop synchroniser bringing the asynchronous switches into CLOCK_50.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] count_next;
        logic             mismatch;
        logic             accept;

        // Count consecutive disagreeing edges; any agreement restarts the
        // count, and reaching the last count accepts the synchronised level.
        always_comb begin
            mismatch   = sync2[g] ^ sw_clean[g];
            accept     = mismatch && (count == CNT_LAST);
            count_next = '0;
            if (mismatch && !accept) begin
                count_next = count + CNT_ONE;
            end
        end

        assign clean_next[g] = accept ? sync2[g] : sw_clean[g];
        assign rise_next[g]  = accept & sync2[g];
        assign fall_next[g]  = accept & ~sync2[g];
        assign pending[g]    = mismatch & ~accept;

        // Per-channel stability counter; reset abandons any pending change.
        always_ff @(posedge CLOCK_50) begin
            if (reset) begin
                count <= '0;
            end else begin
                count <= count_next;
            end
        end
    end

    // Registered outputs: accepted levels, edge pulses and the busy flag,
    // which drops on the same edge the last pending change resolves.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sw_clean <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            busy     <= 1'b0;
        end else begin
            sw_clean <= clean_next;
            sw_rise  <= rise_next;
            sw_fall  <= fall_next;
            busy     <= |pending;
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: directed scenarios plus a randomised run against a
// window-based reference model (a level is accepted once the last
// STABLE_CYCLES synchronised samples since reset all differ from it).
module tb_sw_debounce;

    localparam int WIDTH  = 18;
    localparam int STABLE = 4;

    logic             CLOCK_50 = 1'b0;
    logic             reset    = 1'b1;
    logic [WIDTH-1:0] SW       = '0;
    logic [WIDTH-1:0] sw_clean;
    logic [WIDTH-1:0] sw_rise;
    logic [WIDTH-1:0] sw_fall;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_sync1 = '0;
    logic [WIDTH-1:0] m_sync2 = '0;
    logic [WIDTH-1:0] m_clean = '0;
    logic [WIDTH-1:0] m_rise  = '0;
    logic [WIDTH-1:0] m_fall  = '0;
    logic             m_busy  = 1'b0;
    logic [WIDTH-1:0] hist[$];

    sw_debounce #(
        .WIDTH         (WIDTH),
        .STABLE_CYCLES (STABLE)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .SW       (SW),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .busy     (busy)
    );

    // 100 MHz-style free-running clock for the simulation.
    always #5 CLOCK_50 = ~CLOCK_50;

    // Advance the reference model by one rising edge.
    task automatic model_edge();
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] acc;
        logic             all_diff;
        if (reset) begin
            m_sync1 = '0;
            m_sync2 = '0;
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
            m_busy  = 1'b0;
            hist.delete();
        end else begin
            s = m_sync2;
            hist.push_back(s);
            if (hist.size() > STABLE) void'(hist.pop_front());
            acc = '0;
            if (hist.size() == STABLE) begin
                for (int b = 0; b < WIDTH; b++) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < STABLE; j++) begin
                        if (hist[j][b] == m_clean[b]) all_diff = 1'b0;
                    end
                    acc[b] = all_diff;
                end
            end
            m_rise  = acc & s;
            m_fall  = acc & ~s;
            m_clean = (m_clean & ~acc) | (s & acc);
            m_busy  = |(s ^ m_clean);
            m_sync2 = m_sync1;
            m_sync1 = SW;
        end
    endtask

    // Drive inputs, take one rising edge, update the model, sample 1 unit later.
    task automatic tick(input logic [WIDTH-1:0] sw_v, input logic rst_v);
        SW    = sw_v;
        reset = rst_v;
        @(posedge CLOCK_50);
        model_edge();
        #1;
    endtask

    task automatic settle();
        tick('0, 1'b1);
        tick('0, 1'b1);
        tick('0, 1'b0);
        tick('0, 1'b0);
    endtask

    task automatic test_reset();
        tick('0, 1'b1);
        tick('0, 1'b1);
        checks++;
        if (sw_clean !== '0) begin errors++; $display("[TB] FAIL reset_clean got %h exp 0", sw_clean); end
        checks++;
        if (sw_rise !== '0) begin errors++; $display("[TB] FAIL reset_rise got %h exp 0", sw_rise); end
        checks++;
        if (sw_fall !== '0) begin errors++; $display("[TB] FAIL reset_fall got %h exp 0", sw_fall); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b exp 0", busy); end
    endtask

    task automatic test_latency();
        logic [WIDTH-1:0] exp_c, exp_r;
        logic             exp_b;
        settle();
        for (int k = 0; k < 8; k++) begin
            tick(18'h10000, 1'b0);
            exp_c = (k >= 5) ? 18'h10000 : '0;
            exp_r = (k == 5) ? 18'h10000 : '0;
            exp_b = (k >= 2) && (k <= 4);
            checks++;
            if (sw_clean !== exp_c) begin errors++; $display("[TB] FAIL latency_clean k=%0d got %h exp %h", k, sw_clean, exp_c); end
            checks++;
            if (sw_rise !== exp_r) begin errors++; $display("[TB] FAIL latency_rise k=%0d got %h exp %h", k, sw_rise, exp_r); end
            checks++;
            if (sw_fall !== '0) begin errors++; $display("[TB] FAIL latency_fall k=%0d got %h exp 0", k, sw_fall); end
            checks++;
            if (busy !== exp_b) begin errors++; $display("[TB] FAIL latency_busy k=%0d got %b exp %b", k, busy, exp_b); end
        end
    endtask

    task automatic test_glitch();
        logic [WIDTH-1:0] v;
        settle();
        for (int k = 0; k < 16; k++) begin
            v = (k < 8 && (k % 2) == 0) ? 18'h20000 : '0;
            tick(v, 1'b0);
            checks++;
            if ({sw_clean[17], sw_rise[17], sw_fall[17]} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL glitch_ch17 k=%0d got clean/rise/fall %b%b%b exp 000",
                         k, sw_clean[17], sw_rise[17], sw_fall[17]);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] exp_c, exp_r, exp_f;
        settle();
        for (int k = 0; k < 8; k++) begin
            tick(18'h00009, 1'b0);
            exp_c = (k >= 5) ? 18'h00009 : '0;
            exp_r = (k == 5) ? 18'h00009 : '0;
            checks++;
            if (sw_clean !== exp_c) begin errors++; $display("[TB] FAIL simul_rise_clean k=%0d got %h exp %h", k, sw_clean, exp_c); end
            checks++;
            if (sw_rise !== exp_r) begin errors++; $display("[TB] FAIL simul_rise_pulse k=%0d got %h exp %h", k, sw_rise, exp_r); end
        end
        for (int k = 0; k < 8; k++) begin
            tick(18'h00008, 1'b0);
            exp_c = (k >= 5) ? 18'h00008 : 18'h00009;
            exp_f = (k == 5) ? 18'h00001 : '0;
            checks++;
            if (sw_clean !== exp_c) begin errors++; $display("[TB] FAIL simul_fall_clean k=%0d got %h exp %h", k, sw_clean, exp_c); end
            checks++;
            if (sw_fall !== exp_f) begin errors++; $display("[TB] FAIL simul_fall_pulse k=%0d got %h exp %h", k, sw_fall, exp_f); end
            checks++;
            if (sw_rise !== '0) begin errors++; $display("[TB] FAIL simul_fall_rise k=%0d got %h exp 0", k, sw_rise); end
        end
    endtask

    task automatic test_reset_abort();
        logic [WIDTH-1:0] exp_c, exp_r;
        settle();
        tick(18'h00002, 1'b0);
        tick(18'h00002, 1'b0);
        tick(18'h00002, 1'b1);
        checks++;
        if ({sw_clean, sw_rise, sw_fall} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_in_reset got clean %h rise %h fall %h exp 0", sw_clean, sw_rise, sw_fall);
        end
        for (int j = 0; j < 8; j++) begin
            tick(18'h00002, 1'b0);
            exp_c = (j >= 5) ? 18'h00002 : '0;
            exp_r = (j == 5) ? 18'h00002 : '0;
            checks++;
            if (sw_clean !== exp_c) begin errors++; $display("[TB] FAIL abort_clean j=%0d got %h exp %h", j, sw_clean, exp_c); end
            checks++;
            if (sw_rise !== exp_r) begin errors++; $display("[TB] FAIL abort_rise j=%0d got %h exp %h", j, sw_rise, exp_r); end
        end
    endtask

    task automatic test_mux();
        logic [WIDTH-1:0] target;
        logic [3:0]       d;
        logic             mux_out;
        logic             exp_m;
        target = 18'h30008;
        settle();
        for (int k = 0; k < 6; k++) begin
            tick(((k % 2) == 0) ? target : '0, 1'b0);
            d       = sw_clean[3:0];
            mux_out = d[sw_clean[17:16]];
            checks++;
            if (mux_out !== 1'b0) begin errors++; $display("[TB] FAIL mux_bounce k=%0d got %b exp 0", k, mux_out); end
        end
        for (int k = 0; k < 8; k++) begin
            tick(target, 1'b0);
            d       = sw_clean[3:0];
            mux_out = d[sw_clean[17:16]];
            exp_m   = (k >= 5);
            checks++;
            if (mux_out !== exp_m) begin errors++; $display("[TB] FAIL mux_hold k=%0d got %b exp %b", k, mux_out, exp_m); end
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] cur;
        logic             rst_v;
        cur = '0;
        settle();
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < WIDTH; b++) begin
                if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
            end
            if ($urandom_range(0, 49) == 0) cur = ~cur;
            rst_v = ($urandom_range(0, 149) == 0);
            tick(cur, rst_v);
            checks++;
            if (sw_clean !== m_clean) begin errors++; $display("[TB] FAIL rand_clean n=%0d got %h exp %h", n, sw_clean, m_clean); end
            checks++;
            if (sw_rise !== m_rise) begin errors++; $display("[TB] FAIL rand_rise n=%0d got %h exp %h", n, sw_rise, m_rise); end
            checks++;
            if (sw_fall !== m_fall) begin errors++; $display("[TB] FAIL rand_fall n=%0d got %h exp %h", n, sw_fall, m_fall); end
            checks++;
            if (busy !== m_busy) begin errors++; $display("[TB] FAIL rand_busy n=%0d got %b exp %b", n, busy, m_busy); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_simultaneous();
        test_reset_abort();
        test_mux();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
